pcg_rng_multi: RTL and testbench



---
 rtl/pcg_rng_multi.sv | 152 +++++++++++++++
 tb/tb_pcg_rng_multi.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pcg_rng_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pcg_rng_multi
//  Description : Multi-channel 64-bit LCG random number generator with
//                XSH-RR / legacy output permutation on a Wishbone slave port.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcg_rng_multi #(
    parameter int          CHANNELS     = 4,
    parameter logic [63:0] DEFAULT_SEED = 64'h123456789abcdef0,
    parameter logic [63:0] DEFAULT_MULT = 64'h5851f42d4c957f2d,
    parameter logic [63:0] DEFAULT_INC  = 64'h14057b7ef767814f
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] adr,
    input  logic [31:0] dat_w,
    output logic [31:0] dat_r,
    output logic        ack
);

    localparam logic [1:0] c_K_OUT     = 2'd0;
    localparam logic [1:0] c_K_SEED_HI = 2'd1;
    localparam logic [1:0] c_K_SEED_LO = 2'd2;
    localparam logic [1:0] c_K_INC     = 2'd3;
    localparam logic [2:0] c_LAST_CH   = 3'(CHANNELS - 1);

    logic [63:0] r_state [CHANNELS];
    logic [63:0] r_inc   [CHANNELS];
    logic [63:0] w_next  [CHANNELS];
    logic [63:0] r_mult;
    logic [31:0] r_seed_hold;
    logic [1:0]  r_ctrl;
    logic [31:0] r_dat_r;
    logic        r_ack;

    logic        w_req, w_wr, w_rd;
    logic [5:0]  w_idx;
    logic [2:0]  w_ch;
    logic [1:0]  w_k;
    logic        w_ch_ok, w_glob;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    function automatic logic [31:0] perm_xsh_rr(input logic [63:0] s);
        logic [63:0] t;
        logic [63:0] rr;
        t  = ((s >> 18) ^ s) >> 27;
        rr = {t[31:0], t[31:0]} >> s[63:59];
        return rr[31:0];
    endfunction

    function automatic logic [31:0] perm_legacy(input logic [63:0] s);
        return s[31:0] ^ {18'd0, s[63:50]};
    endfunction

    assign w_req   = cyc & stb & ~r_ack;
    assign w_wr    = w_req & we & (sel == 4'hF);
    assign w_rd    = w_req & ~we;
    assign w_idx   = adr[7:2];
    assign w_ch    = w_idx[4:2];
    assign w_k     = w_idx[1:0];
    assign w_ch_ok = ~w_idx[5] & (w_ch <= c_LAST_CH);
    assign w_glob  = (w_idx[5:2] == 4'b1000);
    assign w_unused_bits = ^{adr[31:8], adr[1:0]};

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_next[c] = r_state[c] * r_mult + r_inc[c];
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_ch_ok) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_ch == 3'(c)) begin
                    case (w_k)
                        c_K_OUT:     w_rdata = r_ctrl[1] ? perm_legacy(r_state[c])
                                                         : perm_xsh_rr(r_state[c]);
                        c_K_SEED_HI: w_rdata = r_state[c][63:32];
                        c_K_SEED_LO: w_rdata = r_state[c][31:0];
                        default:     w_rdata = r_inc[c][31:0];
                    endcase
                end
            end
        end else if (w_glob) begin
            case (w_k)
                2'd0:    w_rdata = {30'd0, r_ctrl};
                2'd1:    w_rdata = r_mult[63:32];
                2'd2:    w_rdata = r_mult[31:0];
                default: w_rdata = {24'd0, 8'(CHANNELS)};
            endcase
        end
    end

    // A seed load wins over a step; reads and free-run share the one step per edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c] <= DEFAULT_SEED ^ 64'(c);
                r_inc[c]   <= (DEFAULT_INC + 64'(2 * c)) | 64'd1;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_wr && w_ch_ok && w_ch == 3'(c) && w_k == c_K_SEED_LO) begin
                    r_state[c] <= {r_seed_hold, dat_w};
                end else if (r_ctrl[0] || (w_rd && w_ch_ok && w_ch == 3'(c) && w_k == c_K_OUT)) begin
                    r_state[c] <= w_next[c];
                end
                if (w_wr && w_ch_ok && w_ch == 3'(c) && w_k == c_K_INC) begin
                    r_inc[c][31:1] <= dat_w[31:1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mult      <= DEFAULT_MULT;
            r_seed_hold <= 32'd0;
            r_ctrl      <= 2'd0;
            r_ack       <= 1'b0;
            r_dat_r     <= 32'd0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_dat_r <= w_rdata;
            end
            if (w_wr && w_ch_ok && w_k == c_K_SEED_HI) begin
                r_seed_hold <= dat_w;
            end
            if (w_wr && w_glob) begin
                case (w_k)
                    2'd0:    r_ctrl         <= dat_w[1:0];
                    2'd1:    r_mult[63:32]  <= dat_w;
                    2'd2:    r_mult[31:0]   <= {dat_w[31:2], 2'b01};
                    default: ;
                endcase
            end
        end
    end

    assign dat_r = r_dat_r;
    assign ack   = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_pcg_rng_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcg_rng_multi
//  Description : Directed self-checking bench for pcg_rng_multi.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcg_rng_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic [31:0] dat_r;
    logic        ack;

    int n_checks = 0;
    int n_errors = 0;

    pcg_rng_multi dut (
        .clk   (clk),
        .rst   (rst),
        .cyc   (cyc),
        .stb   (stb),
        .we    (we),
        .sel   (sel),
        .adr   (adr),
        .dat_w (dat_w),
        .dat_r (dat_r),
        .ack   (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One bus access; returns during the ack cycle with the sampled data.
    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        @(posedge clk);
        #1;
        check("ack", {63'd0, ack}, 64'd1);
        rd = dat_r;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    function automatic logic [31:0] ref_xsh(input logic [63:0] s);
        logic [31:0] x;
        x = 32'((((s >> 18) ^ s) >> 27) & 64'hffff_ffff);
        for (int i = 0; i < int'(s[63:59]); i++) x = {x[0], x[31:1]};
        return x;
    endfunction

    logic [31:0] rd;
    logic [63:0] s3, mult_m;
    localparam logic [63:0] c_INC3 = 64'h14057b7ef7678155;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'd0; dat_w = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {63'd0, ack}, 64'd0);
        check("rst_dat", {32'd0, dat_r}, 64'd0);
        @(negedge clk) rst = 1'b0;

        wb(1'b0, 32'h8C, 32'd0, 4'hF, rd); check("info", {32'd0, rd}, 64'h4);
        @(posedge clk); #1;
        check("ack_single", {63'd0, ack}, 64'd0);
        wb(1'b0, 32'h80, 32'd0, 4'hF, rd); check("ctrl_rst", {32'd0, rd}, 64'h0);
        wb(1'b0, 32'h90, 32'd0, 4'hF, rd); check("unmapped", {32'd0, rd}, 64'h0);

        // Zero seed on channel 0: output 0, next state is the increment.
        wb(1'b1, 32'h04, 32'h0, 4'hF, rd);
        wb(1'b1, 32'h08, 32'h0, 4'hF, rd);
        wb(1'b0, 32'h00, 32'd0, 4'hF, rd); check("ch0_out", {32'd0, rd}, 64'h0);
        wb(1'b0, 32'h08, 32'd0, 4'hF, rd); check("ch0_lo", {32'd0, rd}, 64'hf767814f);
        wb(1'b0, 32'h04, 32'd0, 4'hF, rd); check("ch0_hi", {32'd0, rd}, 64'h14057b7e);

        wb(1'b0, 32'h18, 32'd0, 4'hF, rd); check("ch1_lo", {32'd0, rd}, 64'h9abcdef1);
        wb(1'b0, 32'h1C, 32'd0, 4'hF, rd); check("ch1_inc", {32'd0, rd}, 64'hf7678151);
        wb(1'b1, 32'h1C, 32'h10, 4'hF, rd);
        wb(1'b0, 32'h1C, 32'd0, 4'hF, rd); check("ch1_inc_w", {32'd0, rd}, 64'h11);

        wb(1'b1, 32'h80, 32'h2, 4'hF, rd);
        wb(1'b1, 32'h24, 32'h80000000, 4'hF, rd);
        wb(1'b1, 32'h28, 32'h5, 4'hF, rd);
        wb(1'b0, 32'h20, 32'd0, 4'hF, rd); check("ch2_legacy", {32'd0, rd}, 64'h2005);

        wb(1'b1, 32'h88, 32'h12345678, 4'h3, rd);
        wb(1'b0, 32'h88, 32'd0, 4'hF, rd); check("mult_partial", {32'd0, rd}, 64'h4c957f2d);
        wb(1'b1, 32'h88, 32'h4, 4'hF, rd);
        wb(1'b0, 32'h88, 32'd0, 4'hF, rd); check("mult_lo", {32'd0, rd}, 64'h5);
        mult_m = 64'h5851f42d_00000005;

        // CTRL=1 lands at edge E; run is live for E+1..E+11, where the
        // clearing write lands, so channel 3 steps 11 times.
        wb(1'b1, 32'h80, 32'h1, 4'hF, rd);
        repeat (10) @(posedge clk);
        wb(1'b1, 32'h80, 32'h0, 4'hF, rd);
        s3 = 64'h123456789abcdef3;
        for (int i = 0; i < 11; i++) s3 = s3 * mult_m + c_INC3;
        wb(1'b0, 32'h34, 32'd0, 4'hF, rd); check("ch3_hi_run", {32'd0, rd}, {32'd0, s3[63:32]});
        wb(1'b0, 32'h38, 32'd0, 4'hF, rd); check("ch3_lo_run", {32'd0, rd}, {32'd0, s3[31:0]});
        wb(1'b0, 32'h30, 32'd0, 4'hF, rd); check("ch3_xsh", {32'd0, rd}, {32'd0, ref_xsh(s3)});
        s3 = s3 * mult_m + c_INC3;
        wb(1'b0, 32'h38, 32'd0, 4'hF, rd); check("ch3_lo_step", {32'd0, rd}, {32'd0, s3[31:0]});

        // Reset arriving while an ack is pending.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h00; sel = 4'hF;
        @(posedge clk); #1;
        check("rst_mid_ack", {63'd0, ack}, 64'd1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ack_clr", {63'd0, ack}, 64'd0);
        check("rst_dat_clr", {32'd0, dat_r}, 64'd0);
        @(negedge clk) rst = 1'b0;
        wb(1'b0, 32'h08, 32'd0, 4'hF, rd); check("ch0_lo_rst", {32'd0, rd}, 64'h9abcdef0);
        wb(1'b0, 32'h38, 32'd0, 4'hF, rd); check("ch3_lo_rst", {32'd0, rd}, 64'h9abcdef3);
        wb(1'b0, 32'h1C, 32'd0, 4'hF, rd); check("ch1_inc_rst", {32'd0, rd}, 64'hf7678151);
        wb(1'b0, 32'h88, 32'd0, 4'hF, rd); check("mult_rst", {32'd0, rd}, 64'h4c957f2d);
        wb(1'b0, 32'h80, 32'd0, 4'hF, rd); check("ctrl_rst2", {32'd0, rd}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
